// File: rtl/ppu_reg_interface.sv
// ppu_reg_interface: CPU-facing PPU registers $2000-$2007 with PPUDATA VRAM access path
module ppu_reg_interface #(
    parameter int          INC_ROW   = 32,
    parameter logic [15:0] ADDR_MASK = 16'h3FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_data_out,
    input  logic        vblank_set,
    input  logic        vblank_clr,
    input  logic        sprite0_hit_set,
    input  logic        overflow_set,
    input  logic [7:0]  VRAM_rdata,
    output logic [15:0] VRAM_addr,
    output logic [7:0]  VRAM_data_in,
    output logic        VRAM_WE,
    output logic        VRAM_req,
    output logic        busy,
    output logic [7:0]  ppuctrl,
    output logic [7:0]  ppumask,
    output logic [7:0]  scroll_x,
    output logic [7:0]  scroll_y,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        nmi
);
    localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, RD_CAP = 2'd2;

    logic [1:0]  state;
    logic [15:0] v, t, inc, v_next;
    logic        w, vblank, sprite0, overflow;
    logic [7:0]  rd_buf;
    logic        pd_ok, pd_wr, pd_rd, st_rd;

    assign pd_ok    = (state == IDLE) && !VRAM_WE;
    assign pd_wr    = cpu_we && cpu_addr == 3'd7 && pd_ok;
    assign pd_rd    = cpu_re && cpu_addr == 3'd7 && pd_ok;
    assign st_rd    = cpu_re && cpu_addr == 3'd2;
    assign inc      = ppuctrl[2] ? 16'(INC_ROW) : 16'd1;
    assign v_next   = (v + inc) & ADDR_MASK;
    assign busy     = state != IDLE;
    assign VRAM_req = VRAM_WE | busy;
    assign nmi      = vblank & ppuctrl[7];

    // CPU register writes, OAM pulse and the v/t/w address latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ppuctrl   <= 8'h00;
            ppumask   <= 8'h00;
            scroll_x  <= 8'h00;
            scroll_y  <= 8'h00;
            oam_addr  <= 8'h00;
            oam_wdata <= 8'h00;
            oam_we    <= 1'b0;
            v         <= 16'h0000;
            t         <= 16'h0000;
            w         <= 1'b0;
        end else begin
            oam_we <= cpu_we && cpu_addr == 3'd4;
            if (cpu_we && cpu_addr == 3'd0) ppuctrl <= cpu_data_in;
            if (cpu_we && cpu_addr == 3'd1) ppumask <= cpu_data_in;
            if (cpu_we && cpu_addr == 3'd3) oam_addr <= cpu_data_in;
            else if (oam_we) oam_addr <= oam_addr + 8'd1;
            if (cpu_we && cpu_addr == 3'd4) oam_wdata <= cpu_data_in;
            if (cpu_we && cpu_addr == 3'd5) begin
                if (w) scroll_y <= cpu_data_in;
                else scroll_x <= cpu_data_in;
                w <= ~w;
            end
            if (cpu_we && cpu_addr == 3'd6) begin
                if (w) begin
                    t[7:0] <= cpu_data_in;
                    v      <= {t[15:8], cpu_data_in};
                end else t[15:8] <= {2'b00, cpu_data_in[5:0]};
                w <= ~w;
            end
            if (st_rd) w <= 1'b0;
            if (pd_wr || pd_rd) v <= v_next;
        end
    end

    // PPUDATA VRAM cycles, read FSM and CPU read data latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            VRAM_addr    <= 16'h0000;
            VRAM_data_in <= 8'h00;
            VRAM_WE      <= 1'b0;
            rd_buf       <= 8'h00;
            cpu_data_out <= 8'h00;
        end else begin
            VRAM_WE <= pd_wr;
            state   <= pd_rd ? RD_WAIT : (state == RD_WAIT) ? RD_CAP : IDLE;
            if (pd_wr || pd_rd) VRAM_addr <= v & ADDR_MASK;
            if (pd_wr) VRAM_data_in <= cpu_data_in;
            if (state == RD_CAP) rd_buf <= VRAM_rdata;
            if (pd_rd) cpu_data_out <= rd_buf;
            else if (st_rd) cpu_data_out <= {vblank, sprite0, overflow, cpu_data_out[4:0]};
        end
    end

    // Status flags: set pulses win over clears, vblank_clr wins over renderer sets
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank   <= 1'b0;
            sprite0  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            vblank   <= vblank_set ? 1'b1 : (vblank_clr || st_rd) ? 1'b0 : vblank;
            sprite0  <= vblank_clr ? 1'b0 : sprite0_hit_set ? 1'b1 : sprite0;
            overflow <= vblank_clr ? 1'b0 : overflow_set ? 1'b1 : overflow;
        end
    end
endmodule

// File: tb/tb_ppu_reg_interface.sv
// tb_ppu_reg_interface: directed checks of the PPU register interface with a small VRAM model
module tb_ppu_reg_interface;
    logic        clk = 1'b0, reset = 1'b1;
    logic [2:0]  cpu_addr = 3'd0;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        cpu_we = 1'b0, cpu_re = 1'b0;
    logic [7:0]  cpu_data_out;
    logic        vblank_set = 1'b0, vblank_clr = 1'b0, sprite0_hit_set = 1'b0, overflow_set = 1'b0;
    logic [7:0]  VRAM_rdata;
    logic [15:0] VRAM_addr;
    logic [7:0]  VRAM_data_in;
    logic        VRAM_WE, VRAM_req, busy, oam_we, nmi;
    logic [7:0]  ppuctrl, ppumask, scroll_x, scroll_y, oam_addr, oam_wdata;
    logic [7:0]  mem [0:16383];
    int          checks = 0, failures = 0;

    ppu_reg_interface dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_data_out(cpu_data_out),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr), .sprite0_hit_set(sprite0_hit_set),
        .overflow_set(overflow_set), .VRAM_rdata(VRAM_rdata), .VRAM_addr(VRAM_addr),
        .VRAM_data_in(VRAM_data_in), .VRAM_WE(VRAM_WE), .VRAM_req(VRAM_req), .busy(busy),
        .ppuctrl(ppuctrl), .ppumask(ppumask), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .nmi(nmi)
    );

    always #5 clk = ~clk;

    // synchronous-read VRAM
    always @(posedge clk) begin
        if (VRAM_WE) mem[VRAM_addr[13:0]] <= VRAM_data_in;
        VRAM_rdata <= mem[VRAM_addr[13:0]];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data_in = d;
        cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        cpu_addr = a;
        cpu_re = 1'b1;
        tick();
        cpu_re = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        #2 reset = 1'b0;
        #1;
        chk("rst_ppuctrl", {8'h0, ppuctrl}, 16'h0);
        chk("rst_vaddr", VRAM_addr, 16'h0);
        chk("rst_req", {15'h0, VRAM_req}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_dout", {8'h0, cpu_data_out}, 16'h0);
        chk("rst_nmi", {15'h0, nmi}, 16'h0);
        tick();
        #2 reset = 1'b1;
        tick();
        mem[14'h2400] = 8'h11;
        mem[14'h2401] = 8'h22;
        mem[14'h2402] = 8'h33;
        mem[14'h2403] = 8'h44;

        wr(3'd6, 8'h21);
        wr(3'd6, 8'h08);
        wr(3'd7, 8'h5A);
        chk("w1_we", {15'h0, VRAM_WE}, 16'h1);
        chk("w1_req", {15'h0, VRAM_req}, 16'h1);
        chk("w1_addr", VRAM_addr, 16'h2108);
        chk("w1_data", {8'h0, VRAM_data_in}, 16'h5A);
        tick();
        chk("w1_we_off", {15'h0, VRAM_WE}, 16'h0);
        chk("w1_req_off", {15'h0, VRAM_req}, 16'h0);
        wr(3'd7, 8'h77);
        chk("w2_addr", VRAM_addr, 16'h2109);
        tick();
        chk("w1_mem", {8'h0, mem[14'h2108]}, 16'h5A);

        wr(3'd0, 8'h04);
        wr(3'd6, 8'h20);
        wr(3'd6, 8'h00);
        wr(3'd7, 8'h01);
        chk("row0", VRAM_addr, 16'h2000);
        tick();
        wr(3'd7, 8'h02);
        chk("row1", VRAM_addr, 16'h2020);
        tick();
        wr(3'd7, 8'h03);
        chk("row2", VRAM_addr, 16'h2040);
        tick();
        wr(3'd0, 8'h00);

        wr(3'd6, 8'h24);
        wr(3'd6, 8'h00);
        rd(3'd7);
        chk("rdA_dout", {8'h0, cpu_data_out}, 16'h00);
        chk("rdA_busy1", {15'h0, busy}, 16'h1);
        chk("rdA_req1", {15'h0, VRAM_req}, 16'h1);
        chk("rdA_addr", VRAM_addr, 16'h2400);
        tick();
        chk("rdA_busy2", {15'h0, busy}, 16'h1);
        tick();
        chk("rdA_busy3", {15'h0, busy}, 16'h0);
        chk("rdA_req3", {15'h0, VRAM_req}, 16'h0);
        tick();
        rd(3'd7);
        chk("rdB_dout", {8'h0, cpu_data_out}, 16'h11);
        rd(3'd7);
        chk("drop_dout", {8'h0, cpu_data_out}, 16'h11);
        chk("drop_addr", VRAM_addr, 16'h2401);
        tick();
        chk("rdB_busy_end", {15'h0, busy}, 16'h0);
        rd(3'd7);
        chk("rdC_dout", {8'h0, cpu_data_out}, 16'h22);
        tick();
        tick();
        rd(3'd7);
        chk("rdD_dout", {8'h0, cpu_data_out}, 16'h33);
        tick();
        tick();

        wr(3'd0, 8'h80);
        vblank_set = 1'b1;
        tick();
        vblank_set = 1'b0;
        chk("vbl_nmi", {15'h0, nmi}, 16'h1);
        rd(3'd2);
        chk("st1_dout", {8'h0, cpu_data_out}, 16'h93);
        chk("st1_nmi", {15'h0, nmi}, 16'h0);
        cpu_addr = 3'd2;
        cpu_re = 1'b1;
        vblank_set = 1'b1;
        tick();
        cpu_re = 1'b0;
        vblank_set = 1'b0;
        chk("st2_dout", {8'h0, cpu_data_out}, 16'h13);
        chk("st2_nmi", {15'h0, nmi}, 16'h1);
        vblank_clr = 1'b1;
        tick();
        vblank_clr = 1'b0;
        chk("clr_nmi", {15'h0, nmi}, 16'h0);
        overflow_set = 1'b1;
        tick();
        overflow_set = 1'b0;
        rd(3'd2);
        chk("st3_dout", {8'h0, cpu_data_out}, 16'h33);
        sprite0_hit_set = 1'b1;
        vblank_clr = 1'b1;
        tick();
        sprite0_hit_set = 1'b0;
        vblank_clr = 1'b0;
        rd(3'd2);
        chk("st4_dout", {8'h0, cpu_data_out}, 16'h13);

        wr(3'd0, 8'h00);
        wr(3'd6, 8'h12);
        rd(3'd2);
        wr(3'd6, 8'h3F);
        wr(3'd6, 8'hFF);
        wr(3'd7, 8'hA1);
        chk("wrap1_addr", VRAM_addr, 16'h3FFF);
        tick();
        wr(3'd7, 8'hA2);
        chk("wrap1_next", VRAM_addr, 16'h0000);
        tick();
        wr(3'd0, 8'h04);
        wr(3'd6, 8'h3F);
        wr(3'd6, 8'hE0);
        wr(3'd7, 8'hB1);
        chk("wrap32_addr", VRAM_addr, 16'h3FE0);
        tick();
        wr(3'd7, 8'hB2);
        chk("wrap32_next", VRAM_addr, 16'h0000);
        tick();

        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hAB);
        chk("oam1_we", {15'h0, oam_we}, 16'h1);
        chk("oam1_pair", {oam_addr, oam_wdata}, 16'hFFAB);
        wr(3'd4, 8'hCD);
        chk("oam2_we", {15'h0, oam_we}, 16'h1);
        chk("oam2_pair", {oam_addr, oam_wdata}, 16'h00CD);
        tick();
        chk("oam_we_off", {15'h0, oam_we}, 16'h0);
        chk("oam_addr_end", {8'h0, oam_addr}, 16'h01);
        wr(3'd5, 8'h11);
        wr(3'd5, 8'h22);
        chk("scroll", {scroll_x, scroll_y}, 16'h1122);
        wr(3'd1, 8'h1E);
        chk("ppumask", {8'h0, ppumask}, 16'h1E);
        rd(3'd0);
        chk("wo_read_hold", {8'h0, cpu_data_out}, 16'h13);

        rd(3'd7);
        chk("rdE_dout", {8'h0, cpu_data_out}, 16'h44);
        chk("rdE_busy", {15'h0, busy}, 16'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_busy", {15'h0, busy}, 16'h0);
        chk("mid_req", {15'h0, VRAM_req}, 16'h0);
        chk("mid_we", {15'h0, VRAM_WE}, 16'h0);
        chk("mid_ppuctrl", {8'h0, ppuctrl}, 16'h0);
        chk("mid_dout", {8'h0, cpu_data_out}, 16'h0);
        chk("mid_vaddr", VRAM_addr, 16'h0);
        #1 reset = 1'b1;
        tick();
        rd(3'd7);
        chk("post_rdbuf", {8'h0, cpu_data_out}, 16'h00);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
